// File: rtl/rv32_clint.sv
// -----------------------------------------------------------------------------
// rv32_clint -- core-local interruptor for a single RV32 hart.
//
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and
// the MSIP software-interrupt bit behind a simple req/gnt/rvalid bus.
//
// Register map (byte offsets, addr_i[1:0] ignored):
//   0x0000  MSIP          bit0 R/W, bits 31:1 read 0
//   0x4000  MTIMECMP lo   0x4004  MTIMECMP hi
//   0xBFF8  MTIME lo      0xBFFC  MTIME hi
//   Any other address answers with err_o=1, rdata_o=0 and changes nothing.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_i/we_i/addr_i/be_i/wdata_i   bus request (accepted in its cycle)
//   gnt_o                grant, combinationally equal to req_i
//   rvalid_o/rdata_o/err_o            response, one cycle after the grant
//   time_irq_o           registered (mtime >= mtimecmp), level
//   ipi_o                MSIP bit0
//   mtime_o              current mtime register
//
// Configuration:
//   PITO_CLINT_PRESCALER_EN  when defined, mtime ticks once every
//                            PRESCALE_DIV cycles (8-bit prescaler, 2..255);
//                            when undefined, mtime ticks every cycle and
//                            PRESCALE_DIV has no effect.
// -----------------------------------------------------------------------------
module rv32_clint #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        time_irq_o,
  output logic        ipi_o,
  output logic [63:0] mtime_o
);

  // Word addresses (byte offset >> 2)
  localparam logic [13:0] LP_W_MSIP     = 14'h0000;
  localparam logic [13:0] LP_W_CMP_LO   = 14'h1000;
  localparam logic [13:0] LP_W_CMP_HI   = 14'h1001;
  localparam logic [13:0] LP_W_MTIME_LO = 14'h2FFE;
  localparam logic [13:0] LP_W_MTIME_HI = 14'h2FFF;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_time_irq;
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;

  logic [13:0] w_word;
  logic        w_sel_msip;
  logic        w_sel_cmp_lo;
  logic        w_sel_cmp_hi;
  logic        w_sel_mtime_lo;
  logic        w_sel_mtime_hi;
  logic        w_mapped;
  logic        w_wr;
  logic        w_mtime_lo_wr;
  logic        w_mtime_hi_wr;
  logic        w_mtime_wr;
  logic        w_tick;
  logic [31:0] w_rd_mux;
  logic [63:0] w_mtime_next;
  logic [1:0]  w_unused_addr;

  // Byte-lane merge: bytes with be set take the new data, others keep old.
  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign w_word         = addr_i[15:2];
  assign w_unused_addr  = addr_i[1:0];
  assign w_sel_msip     = (w_word == LP_W_MSIP);
  assign w_sel_cmp_lo   = (w_word == LP_W_CMP_LO);
  assign w_sel_cmp_hi   = (w_word == LP_W_CMP_HI);
  assign w_sel_mtime_lo = (w_word == LP_W_MTIME_LO);
  assign w_sel_mtime_hi = (w_word == LP_W_MTIME_HI);
  assign w_mapped       = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi |
                          w_sel_mtime_lo | w_sel_mtime_hi;

  assign w_wr           = req_i & we_i;
  // A be_i=0 write is a pure no-op: it neither freezes mtime nor touches the
  // prescaler.
  assign w_mtime_lo_wr  = w_wr & w_sel_mtime_lo & (|be_i);
  assign w_mtime_hi_wr  = w_wr & w_sel_mtime_hi & (|be_i);
  assign w_mtime_wr     = w_mtime_lo_wr | w_mtime_hi_wr;

`ifdef PITO_CLINT_PRESCALER_EN
  localparam logic [7:0] LP_PRESC_LAST = 8'(PRESCALE_DIV - 1);

  logic [7:0] r_presc;

  assign w_tick = (r_presc == LP_PRESC_LAST);

  // Counts 0..PRESCALE_DIV-1; a software write to mtime restarts the period
  // so the first tick after the write comes a full period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 8'd0;
    end else if (w_mtime_wr || w_tick) begin
      r_presc <= 8'd0;
    end else begin
      r_presc <= r_presc + 8'd1;
    end
  end
`else
  localparam int unsigned LP_UNUSED_DIV = PRESCALE_DIV;

  assign w_tick = 1'b1;
`endif

  // Software writes win over a coincident tick: the merged value is loaded
  // and no increment happens that cycle.
  always_comb begin
    w_mtime_next = r_mtime;
    if (w_mtime_lo_wr) begin
      w_mtime_next = {r_mtime[63:32], f_merge(r_mtime[31:0], wdata_i, be_i)};
    end else if (w_mtime_hi_wr) begin
      w_mtime_next = {f_merge(r_mtime[63:32], wdata_i, be_i), r_mtime[31:0]};
    end else if (w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
  end

  // Read mux sees the pre-update register values, so a read coinciding with
  // a tick returns the pre-increment count.
  always_comb begin
    w_rd_mux = 32'd0;
    if (w_sel_msip)     w_rd_mux = {31'd0, r_msip};
    if (w_sel_cmp_lo)   w_rd_mux = r_mtimecmp[31:0];
    if (w_sel_cmp_hi)   w_rd_mux = r_mtimecmp[63:32];
    if (w_sel_mtime_lo) w_rd_mux = r_mtime[31:0];
    if (w_sel_mtime_hi) w_rd_mux = r_mtime[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
      r_time_irq <= 1'b0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_mtime <= w_mtime_next;

      if (w_wr && w_sel_cmp_lo) begin
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], wdata_i, be_i);
      end
      if (w_wr && w_sel_cmp_hi) begin
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], wdata_i, be_i);
      end
      if (w_wr && w_sel_msip && be_i[0]) begin
        r_msip <= wdata_i[0];
      end

      // Compare uses this cycle's registers, giving one cycle of latency.
      r_time_irq <= (r_mtime >= r_mtimecmp);

      r_rvalid <= req_i;
      r_err    <= req_i & ~w_mapped;
      r_rdata  <= (req_i && !we_i && w_mapped) ? w_rd_mux : 32'd0;
    end
  end

  assign gnt_o      = req_i;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = r_rdata;
  assign err_o      = r_err;
  assign time_irq_o = r_time_irq;
  assign ipi_o      = r_msip;
  assign mtime_o    = r_mtime;

endmodule

// File: tb/tb_rv32_clint.sv
// -----------------------------------------------------------------------------
// tb_rv32_clint -- self-checking bench for rv32_clint.
// Bus accesses push their expected response into a queue; an independent
// monitor pops and compares whenever rvalid_o is seen. Side-band outputs
// (mtime_o, time_irq_o, ipi_o) are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_rv32_clint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        we_i;
  logic [15:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        time_irq_o;
  logic        ipi_o;
  logic [63:0] mtime_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic [15:0] addr;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  rv32_clint #(.PRESCALE_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .time_irq_o (time_irq_o),
    .ipi_o      (ipi_o),
    .mtime_o    (mtime_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rvalid_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("rsp %s addr=0x%04h err=%0b rdata=0x%08h (exp err=%0b rdata=0x%08h)",
                 e.we ? "WR" : "RD", e.addr, err_o, rdata_o, e.err, e.rdata);
        check("rsp_err", {63'd0, err_o}, {63'd0, e.err});
        check("rsp_rdata", {32'd0, rdata_o}, {32'd0, e.rdata});
      end
    end
  end

  // One access: driven 1ns after a rising edge, sampled on the next edge,
  // request removed 1ns after that edge. Returns 1ns after the sampling edge.
  task automatic bus(input logic we, input logic [15:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    @(posedge clk);
    #1;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    be_i    = be;
    wdata_i = wd;
    e.err   = e_err;
    e.rdata = e_rd;
    e.we    = we;
    e.addr  = addr;
    sb_q.push_back(e);
    #1;
    check("gnt", {63'd0, gnt_o}, 64'd1);
    @(posedge clk);
    #1;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 16'd0;
    be_i    = 4'd0;
    wdata_i = 32'd0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wd);
    bus(1'b1, addr, be, wd, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp);
    bus(1'b0, addr, 4'hF, 32'd0, 1'b0, exp);
  endtask

  // Reset asserted while a request is on the bus: the request is dropped.
  task automatic reset_mid_request();
    wr(16'h0000, 4'hF, 32'h1);
    check("ipi_before_rst", {63'd0, ipi_o}, 64'd1);
    @(posedge clk);
    #1;
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 16'hBFF8;
    be_i   = 4'hF;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mtime", mtime_o, 64'd0);
    check("rst_irq", {63'd0, time_irq_o}, 64'd0);
    check("rst_ipi", {63'd0, ipi_o}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
    check("rst_rdata", {32'd0, rdata_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    req_i  = 1'b0;
    addr_i = 16'd0;
    be_i   = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", {63'd0, rvalid_o}, 64'd0);
    end
    rd(16'h0000, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] t0;
    bit          found;

    rst_n   = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 16'd0;
    be_i    = 4'd0;
    wdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mtime", mtime_o, 64'd0);
    check("reset_irq", {63'd0, time_irq_o}, 64'd0);
    check("reset_ipi", {63'd0, ipi_o}, 64'd0);
    check("reset_rvalid", {63'd0, rvalid_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef PITO_CLINT_PRESCALER_EN
    // 40 cycles at divide-by-4 is exactly 10 ticks whatever the phase.
    @(negedge clk);
    t0 = mtime_o;
    repeat (40) @(negedge clk);
    check("presc_advance", mtime_o - t0, 64'd10);
    reset_mid_request();
`else
    // 10 cycles after reset release: mtime counted 1..10.
    repeat (9) @(posedge clk);
    rd(16'hBFF8, 32'd10);
    check("idle_irq", {63'd0, time_irq_o}, 64'd0);
    check("idle_ipi", {63'd0, ipi_o}, 64'd0);

    // MSIP
    wr(16'h0000, 4'hF, 32'h1);
    check("ipi_set", {63'd0, ipi_o}, 64'd1);
    rd(16'h0000, 32'h1);
    wr(16'h0000, 4'hF, 32'h0);
    check("ipi_clr", {63'd0, ipi_o}, 64'd0);
    wr(16'h0000, 4'h2, 32'h1);
    check("ipi_be_masked", {63'd0, ipi_o}, 64'd0);

    // Timer interrupt: mtime=5, then mtimecmp=0x20
    wr(16'hBFFC, 4'hF, 32'h0);
    wr(16'hBFF8, 4'hF, 32'h5);
    check("mtime_loaded", mtime_o, 64'd5);
    wr(16'h4000, 4'hF, 32'h20);
    wr(16'h4004, 4'hF, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (mtime_o == 64'h20) begin
        found = 1'b1;
        break;
      end
    end
    check("irq_wait", {63'd0, found}, 64'd1);
    check("irq_at_match", {63'd0, time_irq_o}, 64'd0);
    @(negedge clk);
    check("irq_rise", {63'd0, time_irq_o}, 64'd1);
    repeat (5) @(negedge clk);
    check("irq_level", {63'd0, time_irq_o}, 64'd1);
    wr(16'h4004, 4'hF, 32'h1);
    check("irq_hold", {63'd0, time_irq_o}, 64'd1);
    @(posedge clk);
    #1;
    check("irq_fall", {63'd0, time_irq_o}, 64'd0);

    // Full 64-bit wrap
    wr(16'hBFFC, 4'hF, 32'hFFFF_FFFF);
    wr(16'hBFF8, 4'hF, 32'hFFFF_FFFE);
    check("wrap_m2", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk);
    #1;
    check("wrap_m1", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    check("wrap_zero", mtime_o, 64'd0);
    @(posedge clk);
    #1;
    check("wrap_irq_clr", {63'd0, time_irq_o}, 64'd0);

    // Low-to-high carry
    wr(16'hBFFC, 4'hF, 32'h0);
    wr(16'hBFF8, 4'hF, 32'hFFFF_FFFF);
    check("carry_pre", mtime_o, 64'h0000_0000_FFFF_FFFF);
    @(posedge clk);
    #1;
    check("carry_post", mtime_o, 64'h0000_0001_0000_0000);
    rd(16'hBFFC, 32'h1);

    // Unmapped accesses and no-op writes
    bus(1'b0, 16'h1000, 4'hF, 32'h0, 1'b1, 32'h0);
    bus(1'b1, 16'h8000, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0);
    bus(1'b0, 16'h4008, 4'hF, 32'h0, 1'b1, 32'h0);
    wr(16'h4000, 4'h0, 32'hFFFF_FFFF);
    rd(16'h4000, 32'h20);
    rd(16'h4007, 32'h1);
    rd(16'h0000, 32'h0);

    // Byte-lane write to MTIME lo: lo = 0x11223300, ticks to ..01, byte1 <- AB
    wr(16'hBFF8, 4'hF, 32'h1122_3300);
    wr(16'hBFF8, 4'h2, 32'h0000_AB00);
    check("be_mtime", mtime_o, 64'h0000_0001_1122_AB01);

    reset_mid_request();
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_clint.md
RV32_CLINT -- requirements
Module: rv32_clint

Interface
REQ-001 SHALL have parameter PRESCALE_DIV, default 4, mtime tick divider (range 2..255); used only when the Configuration macro is defined.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports:
- req_i  input  1  bus request
- we_i  input  1  write enable
- addr_i  input  16  byte address
- be_i  input  4  byte enables
- wdata_i  input  32  write data
REQ-005 SHALL have ports:
- gnt_o  output  1  grant
- rvalid_o  output  1  response valid
- rdata_o  output  32  read data
- err_o  output  1  access error
REQ-006 SHALL have ports:
- time_irq_o  output  1  timer interrupt, to the CSR file time_irq_i
- ipi_o  output  1  software interrupt, to the CSR file ipi_i
- mtime_o  output  64  current mtime value

Function
REQ-007 Register map SHALL be (byte offsets; other addresses unmapped; addr_i[1:0] ignored):
- 0x0000 MSIP: bit0 R/W; bits 31:1 read 0.
- 0x4000 MTIMECMP[31:0]; 0x4004 MTIMECMP[63:32].
- 0xBFF8 MTIME[31:0]; 0xBFFC MTIME[63:32].
REQ-008 gnt_o SHALL equal req_i combinationally; every request is accepted in its cycle.
REQ-009 rvalid_o SHALL pulse high exactly one cycle after each granted request, for one cycle.
REQ-010 Read data SHALL be registered. rdata_o is valid with rvalid_o, holds the value sampled in the grant cycle, and is 0 when rvalid_o is low.
REQ-011 Writes SHALL apply only to bytes with be_i set. be_i=0 is a legal no-op write with a normal response.
REQ-012 An access to an unmapped address SHALL give err_o=1 with rvalid_o, rdata_o=0 and no state change.
REQ-013 mtime SHALL be a 64-bit unsigned counter incremented by 1 on each tick, with full carry from the low to the high word in the same cycle.
REQ-014 mtime SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-015 When a write to MTIME lo or hi coincides with a tick, the write SHALL win: new mtime is the byte-merged written value, with no increment that cycle.
REQ-016 Any write to MTIME SHALL reset the prescaler count to 0 (macro defined).
REQ-017 time_irq_o SHALL be registered and equal (mtime >= mtimecmp), unsigned 64-bit, evaluated on the previous cycle's register values (1-cycle latency).
REQ-018 time_irq_o SHALL be level, not pulse; it clears only when mtimecmp is raised above mtime or mtime wraps.
REQ-019 ipi_o SHALL equal the MSIP bit0 register directly (no extra latency beyond the write cycle).
REQ-020 mtime_o SHALL equal the mtime register.
REQ-021 A read in the same cycle as a tick SHALL return the pre-increment value.

Reset
REQ-022 On rst_n low, asynchronously:
- mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, MSIP=0, prescaler=0
- rvalid_o=0, rdata_o=0, err_o=0, time_irq_o=0, ipi_o=0
REQ-023 A request in progress when reset asserts SHALL be dropped; no rvalid_o follows reset deassertion.

Configuration
REQ-024 With macro PITO_CLINT_PRESCALER_EN defined, a tick SHALL occur once every PRESCALE_DIV cycles, using an 8-bit prescaler counting 0..PRESCALE_DIV-1.
REQ-025 Without PITO_CLINT_PRESCALER_EN, a tick SHALL occur every clk cycle, no prescaler logic SHALL exist, and PRESCALE_DIV is ignored.

Verification
REQ-026 Reset, then 10 idle cycles (macro off) -> read 0xBFF8 returns 10 ±1 (pre-increment at the grant cycle); time_irq_o=0; ipi_o=0.
REQ-027 Write 0x0000=0x1 -> ipi_o=1 the next cycle; read 0x0000 returns 0x1; write 0x0 -> ipi_o=0.
REQ-028 Write MTIMECMP lo=0x20, hi=0 at mtime≈5 -> time_irq_o rises exactly 1 cycle after mtime reaches 0x20; rewrite MTIMECMP hi=1 -> time_irq_o falls the next cycle.
REQ-029 Write MTIME lo=0xFFFF_FFFE, hi=0xFFFF_FFFF -> mtime wraps to 0 after 2 ticks; carry 0x0000_0000_FFFF_FFFF -> 0x0000_0001_0000_0000 checked separately.
REQ-030 Read 0x1000, and write 0x8000 with be_i=0xF -> err_o=1 with rvalid_o, rdata_o=0, no register changes; then write MTIME lo with be_i=0x2, data 0xAB00 -> only byte1 changes.
REQ-031 Macro on, PRESCALE_DIV=4: 40 cycles -> mtime advances by 10; assert rst_n mid-request -> rvalid_o stays 0 and all outputs return to reset values.
